// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one 3-tap FIR MAC across NUM_CH sample streams.
// Each channel owns a two-deep delay line; results leave on a valid/ready port tagged with the channel id.
module fir_channel_scheduler #(
    parameter int               NUM_CH    = 4,
    parameter int               OUT_SHIFT = 8,
    parameter logic signed [7:0] C0_RST   = 8'sd1,
    parameter logic signed [7:0] C1_RST   = 8'sd2,
    parameter logic signed [7:0] C2_RST   = 8'sd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH*8-1:0] in_data,
    input  logic [NUM_CH-1:0]   in_valid,
    output logic [NUM_CH-1:0]   in_ready,
    output logic [7:0]          out_data,
    output logic [2:0]          out_ch,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [7:0]          cfg_data,
    input  logic                hist_clr
);

    localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        MAC1 = 3'd2,
        MAC2 = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t             state_q;
    logic [CH_W-1:0]    rr_q;
    logic [CH_W-1:0]    g_q;
    logic [7:0]         x0_q;
    logic [7:0]         h1_q [NUM_CH];
    logic [7:0]         h2_q [NUM_CH];
    logic signed [7:0]  csh_q [3];
    logic signed [7:0]  cact_q [3];
    logic signed [17:0] acc_q;
    logic [7:0]         out_data_q;
    logic [2:0]         out_ch_q;
    logic               out_valid_q;
    logic               pend_q;

    logic               gfound_s;
    logic [CH_W-1:0]    gidx_s;
    logic [NUM_CH-1:0]  grant_s;
    logic [7:0]         gx_s;
    logic               hs_s;
    logic signed [7:0]  coef_s;
    logic [7:0]         opnd_s;
    logic signed [16:0] prod_s;
    logic signed [17:0] acc_d;
    logic [CH_W-1:0]    rr_d;

    // Rotating priority grant: the lower-pass fills in channels below rr, the upper pass overrides with those at/after rr.
    always_comb begin
        gfound_s = 1'b0;
        gidx_s   = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_valid[i] && (CH_W'(i) < rr_q)) begin
                gfound_s = 1'b1;
                gidx_s   = CH_W'(i);
            end else begin
                gfound_s = gfound_s;
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_valid[i] && (CH_W'(i) >= rr_q)) begin
                gfound_s = 1'b1;
                gidx_s   = CH_W'(i);
            end else begin
                gfound_s = gfound_s;
            end
        end
        grant_s = {NUM_CH{1'b0}};
        gx_s    = 8'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_s[i] = (state_q == IDLE) && gfound_s && (gidx_s == CH_W'(i));
            gx_s       = gx_s | (in_data[8*i +: 8] & {8{grant_s[i]}});
        end
    end

    assign in_ready = grant_s;
    assign hs_s     = |(in_valid & grant_s);

    // Tap selection and accumulate; sign handling is done on explicit 17-bit operands so the bit pattern is exact.
    always_comb begin
        case (state_q)
            MAC0:    begin coef_s = cact_q[0]; opnd_s = x0_q;       end
            MAC1:    begin coef_s = cact_q[1]; opnd_s = h1_q[g_q];  end
            MAC2:    begin coef_s = cact_q[2]; opnd_s = h2_q[g_q];  end
            default: begin coef_s = 8'sd0;     opnd_s = 8'd0;       end
        endcase
        prod_s = {{9{coef_s[7]}}, coef_s} * {9'd0, opnd_s};
        acc_d  = (state_q == MAC0) ? {prod_s[16], prod_s} : acc_q + {prod_s[16], prod_s};
        rr_d   = (g_q == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : g_q + CH_W'(1'b1);
    end

    // Scheduler FSM, coefficient shadowing and per-channel delay lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= {CH_W{1'b0}};
            g_q         <= {CH_W{1'b0}};
            x0_q        <= 8'd0;
            acc_q       <= 18'sd0;
            out_data_q  <= 8'd0;
            out_ch_q    <= 3'd0;
            out_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                h1_q[i] <= 8'd0;
                h2_q[i] <= 8'd0;
            end
            csh_q[0]  <= C0_RST;
            csh_q[1]  <= C1_RST;
            csh_q[2]  <= C2_RST;
            cact_q[0] <= C0_RST;
            cact_q[1] <= C1_RST;
            cact_q[2] <= C2_RST;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    csh_q[0] <= $signed(cfg_data);
                    2'd1:    csh_q[1] <= $signed(cfg_data);
                    2'd2:    csh_q[2] <= $signed(cfg_data);
                    default: csh_q[0] <= csh_q[0];
                endcase
            end
            case (state_q)
                IDLE: begin
                    if (hs_s) begin
                        x0_q    <= gx_s;
                        g_q     <= gidx_s;
                        cact_q  <= csh_q;
                        pend_q  <= pend_q | hist_clr;
                        state_q <= MAC0;
                    end else if (hist_clr) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            h1_q[i] <= 8'd0;
                            h2_q[i] <= 8'd0;
                        end
                    end
                end
                MAC0: begin
                    acc_q   <= acc_d;
                    pend_q  <= pend_q | hist_clr;
                    state_q <= MAC1;
                end
                MAC1: begin
                    acc_q   <= acc_d;
                    pend_q  <= pend_q | hist_clr;
                    state_q <= MAC2;
                end
                MAC2: begin
                    acc_q       <= acc_d;
                    out_data_q  <= acc_d[OUT_SHIFT +: 8];
                    out_ch_q    <= 3'(g_q);
                    out_valid_q <= 1'b1;
                    pend_q      <= pend_q | hist_clr;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        h2_q[g_q] <= h1_q[g_q];
                        h1_q[g_q] <= x0_q;
                        // A deferred clear lands after the update, so it wins.
                        if (pend_q || hist_clr) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                h1_q[i] <= 8'd0;
                                h2_q[i] <= 8'd0;
                            end
                        end
                        pend_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                        rr_q        <= rr_d;
                        state_q     <= IDLE;
                    end else begin
                        pend_q <= pend_q | hist_clr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler: a transaction-level model predicts each result at grant time,
// a separate monitor compares whatever the DUT presents on its output port.
module tb_fir_channel_scheduler;

    localparam int N  = 4;
    localparam int SH = 0;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*8-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [7:0]     out_data;
    logic [2:0]     out_ch;
    logic           out_valid;
    logic           out_ready;
    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [7:0]     cfg_data;
    logic           hist_clr;

    fir_channel_scheduler #(.NUM_CH(N), .OUT_SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .hist_clr(hist_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int data;
        int ch;
        int hs;
    } exp_t;
    exp_t sb[$];

    // Reference model state: shadow coefficients and the last two accepted samples per channel.
    int m_sh [3];
    int m_h1 [N];
    int m_h2 [N];
    int m_rr, m_busy, m_age, m_pend, m_ch, m_x;
    int mon_prev = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear_hist();
        for (int i = 0; i < N; i++) begin
            m_h1[i] = 0;
            m_h2[i] = 0;
        end
    endtask

    task automatic model_reset();
        m_sh[0] = 1; m_sh[1] = 2; m_sh[2] = 1;
        model_clear_hist();
        m_rr = 0; m_busy = 0; m_age = 0; m_pend = 0; m_ch = 0; m_x = 0;
        sb.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: sees what the upcoming edge will do and predicts grant, timing and result.
    always @(negedge clk) begin
        int g;
        int acc;
        exp_t e;
        if (rst) begin
            model_reset();
        end else begin
            g = m_busy ? -1 : pick(in_valid, m_rr);
            chk("in_ready", int'(in_ready), (g < 0) ? 0 : (1 << g));
            chk("out_valid", int'(out_valid), (m_busy != 0 && m_age >= 4) ? 1 : 0);
            if (m_busy != 0) begin
                if (hist_clr) m_pend = 1;
                if (m_age >= 4 && out_ready) begin
                    m_h2[m_ch] = m_h1[m_ch];
                    m_h1[m_ch] = m_x;
                    if (m_pend != 0) model_clear_hist();
                    m_pend = 0;
                    m_rr   = (m_ch + 1) % N;
                    m_busy = 0;
                end else begin
                    m_age++;
                end
            end else if (g >= 0) begin
                m_x    = int'(in_data[g*8 +: 8]);
                acc    = m_sh[0] * m_x + m_sh[1] * m_h1[g] + m_sh[2] * m_h2[g];
                e.data = (acc >>> SH) & 255;
                e.ch   = g;
                e.hs   = cyc;
                sb.push_back(e);
                m_ch   = g;
                m_busy = 1;
                m_age  = 1;
                m_pend = hist_clr ? 1 : 0;
            end else if (hist_clr) begin
                model_clear_hist();
            end
            if (cfg_we && cfg_addr != 2'd3) m_sh[int'(cfg_addr)] = int'($signed(cfg_data));
        end
    end

    // Monitor: compares every presented output against the oldest prediction.
    always @(negedge clk) begin
        if (rst) begin
            mon_prev = 0;
        end else begin
            if (out_valid) begin
                chk("output_expected", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    chk("out_data", int'(out_data), sb[0].data);
                    chk("out_ch", int'(out_ch), sb[0].ch);
                    if (mon_prev == 0) chk("latency", cyc - sb[0].hs, 4);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            mon_prev = out_valid ? 1 : 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int ch, input int x);
        int ok;
        ok = 0;
        in_data[ch*8 +: 8] = 8'(x);
        in_valid[ch] = 1'b1;
        for (int k = 0; k < 100 && ok == 0; k++) begin
            @(negedge clk);
            if (in_ready[ch]) ok = 1;
        end
        chk("grant_wait", ok, 1);
        tick();
        in_valid[ch] = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 2'(a);
        cfg_data = 8'(d);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_clr();
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0; hist_clr = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        tick();

        // ch0 stream with default coefficients
        send(0, 100); send(0, 200); send(0, 50);
        idle(6);

        // all taps 64, address 3 must be ignored
        cfg_write(0, 64); cfg_write(1, 64); cfg_write(2, 64); cfg_write(3, 8'h80);
        send(1, 255); send(1, 255); send(1, 255);
        idle(6);

        // all channels requesting: round-robin order and independent histories
        in_valid = '1;
        repeat (30) begin
            in_data = (N*8)'({$urandom, $urandom});
            tick();
        end
        in_valid = '0;
        idle(6);

        // output stall of more than 10 cycles
        out_ready = 1'b0;
        send(3, 123);
        idle(14);
        out_ready = 1'b1;
        idle(3);

        // coefficient write during MAC1 only affects the next sample
        pulse_clr();
        send(2, 90);
        tick();
        cfg_write(0, 8'hFF);
        idle(5);
        pulse_clr();
        send(2, 255);
        idle(6);

        // reset in MAC2, then deferred history clear during OUT
        send(0, 77);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);
        send(0, 100);
        idle(6);
        out_ready = 1'b0;
        send(1, 50);
        ok = 0;
        for (int k = 0; k < 20 && ok == 0; k++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        chk("stall_reach_out", ok, 1);
        tick();
        pulse_clr();
        idle(3);
        out_ready = 1'b1;
        idle(3);
        send(1, 60);
        idle(6);

        // randomized traffic
        repeat (400) begin
            in_valid  = N'($urandom);
            in_data   = (N*8)'({$urandom, $urandom});
            out_ready = ($urandom_range(3) != 0);
            cfg_we    = ($urandom_range(7) == 0);
            cfg_addr  = 2'($urandom);
            cfg_data  = 8'($urandom);
            hist_clr  = ($urandom_range(15) == 0);
            rst       = ($urandom_range(150) == 0);
            tick();
        end
        in_valid = '0; cfg_we = 1'b0; hist_clr = 1'b0; rst = 1'b0; out_ready = 1'b1;
        idle(10);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Time-multiplexes one 3-tap FIR multiply-accumulate datapath across NUM_CH independent sample streams. Each channel keeps its own two-sample delay line. A round-robin arbiter grants one pending input at a time. The block sequences the taps over three MAC cycles and presents the scaled result on a valid/ready output tagged with the channel id. Coefficients are runtime-configurable through a shadowed write port.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
OUT_SHIFT, 8, LSB index of the 8-bit output slice taken from the accumulator (0..10)
C0_RST, 8'sd1, reset value of coefficient 0
C1_RST, 8'sd2, reset value of coefficient 1
C2_RST, 8'sd1, reset value of coefficient 2

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
in_data  in  NUM_CH*8  channel samples, unsigned, ch k at [8k+7:8k]
in_valid  in  NUM_CH  per-channel sample request
in_ready  out  NUM_CH  one-hot grant; handshake when in_valid[k]&in_ready[k]
out_data  out  8  acc[OUT_SHIFT+7:OUT_SHIFT]
out_ch  out  3  channel id of out_data
out_valid  out  1  result valid
out_ready  in  1  downstream accept
cfg_we  in  1  coefficient write strobe
cfg_addr  in  2  coefficient index 0..2; 3 ignored
cfg_data  in  8  signed coefficient value
hist_clr  in  1  pulse: clear all channel delay lines

Behaviour:
- FSM states: IDLE, MAC0, MAC1, MAC2, OUT.
- Reset (sync, any state): state=IDLE; out_valid=0, out_data=0, out_ch=0, in_ready=0; all histories h1/h2=0; shadow and active coefficients = C*_RST; rr pointer=0; pending clear=0.
- IDLE: in_ready is the combinational one-hot grant. It selects the first asserted in_valid at or after rr pointer, wrapping modulo NUM_CH. in_ready=0 when no in_valid is set, and it is 0 in all other states.
  - On handshake: latch sample x0 and channel g; copy shadow coefficients to the active set; go to MAC0.
- MAC0: acc = c0*x0. MAC1: acc += c1*h1[g]. MAC2: acc += c2*h2[g]. Then go to OUT.
- Arithmetic: samples zero-extended to 9-bit signed; coefficients signed 8-bit; products signed 17-bit; acc signed 18-bit. No saturation. out_data is a pure bit slice of the two's-complement acc.
- OUT: out_valid=1, with out_data/out_ch held stable until out_ready.
  - On accept: h2[g]<=h1[g], h1[g]<=x0; rr pointer <= (g+1) mod NUM_CH; out_valid<=0; go to IDLE.
- Latency: handshake in cycle T; out_valid first high in T+4. Minimum 5 cycles per sample with out_ready tied high.
- History updates only on output accept. A stalled output never corrupts the delay lines.
- cfg writes are accepted any cycle and go into the shadow set. Active coefficients change only at grant, so a write during MAC/OUT affects the next sample only. A same-cycle write and grant uses the pre-write value. cfg_addr=3 has no effect.
- hist_clr: clears all h1/h2 immediately if state=IDLE and no handshake occurs that cycle. Otherwise it sets a pending flag, and the clear is applied on the cycle the FSM re-enters IDLE, after that cycle's history update.
- in_valid deasserting while ungranted: no effect. in_data for ungranted channels: ignored.
- Unused out_ch bits are zero.

Test Plan:
- Reset, then ch0 sends 100, 200, 50 with default coeffs, OUT_SHIFT=0 build → out_data 100, 144 (400 mod 256), 38 (550 mod 256); out_ch=0 each time; out_valid exactly 4 cycles after each handshake.
- Default build, coeffs written to 64,64,64; ch1 sends 255 three times → out_data 63, 127, 191.
- All 4 in_valid held high from reset, out_ready=1 → grants in order 0,1,2,3,0; each channel's history is independent (ch0's 2nd output uses only ch0 samples).
- out_ready held low 10 cycles in OUT → out_data/out_ch/out_valid stable; no in_ready asserted; history unchanged until accept.
- Write c0=-1 (8'hFF) while in MAC1 → current result unchanged. Next sample 255 with h1=h2=0 → acc=-255, out_data=8'hFF.
- Assert rst in MAC2 → next cycle out_valid=0, state IDLE. The following ch0 sample 100 with default coeffs → acc=100 (histories cleared). hist_clr pulsed during OUT → clear applied after the update, and the next output equals c0*x0.
